// File: rtl/uart_rx_fifo.sv
// Receive-side frame buffer behind the UART RX parallelizer: queues {stop, parity, data}
// entries and serves them show-ahead over valid/ready, with overrun and error-count status.
module uart_rx_fifo #(
    parameter int DATA_WIDTH      = 8,
    parameter int DEPTH           = 8,
    parameter int ADDR_WIDTH      = 3,
    parameter int DROP_ERR_FRAMES = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  WR_PAR_ERR,
    input  logic                  WR_STP_ERR,
    input  logic                  WR_VALID,
    input  logic                  RD_READY,
    input  logic                  OVR_CLR,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_PAR_ERR,
    output logic                  RD_STP_ERR,
    output logic                  RD_VALID,
    output logic [ADDR_WIDTH:0]   FIFO_COUNT,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  OVERRUN,
    output logic [7:0]            ERR_CNT
);

    logic [DATA_WIDTH+1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [DATA_WIDTH+1:0] head;
    logic                  err;
    logic                  drop;
    logic                  pop;
    logic                  store;
    logic                  ovr;

    always_comb begin
        EMPTY      = (wr_ptr == rd_ptr);
        FULL       = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                     (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
        FIFO_COUNT = wr_ptr - rd_ptr;
        RD_VALID   = !EMPTY;
        err        = WR_PAR_ERR | WR_STP_ERR;
        drop       = (DROP_ERR_FRAMES != 0) && err;
        pop        = RD_VALID && RD_READY;
        // a pop in the same cycle frees the slot, so a full FIFO still accepts the frame
        store      = WR_VALID && !drop && (!FULL || pop);
        ovr        = WR_VALID && !drop && FULL && !pop;
    end

    // Head is gated so stale memory is never visible after reset or drain
    always_comb begin
        head       = mem[rd_ptr[ADDR_WIDTH-1:0]];
        RD_DATA    = EMPTY ? '0 : head[DATA_WIDTH-1:0];
        RD_PAR_ERR = EMPTY ? 1'b0 : head[DATA_WIDTH];
        RD_STP_ERR = EMPTY ? 1'b0 : head[DATA_WIDTH+1];
    end

    always_ff @(posedge CLK) begin
        if (store) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {WR_STP_ERR, WR_PAR_ERR, WR_DATA};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            OVERRUN <= 1'b0;
            ERR_CNT <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (ovr) begin
                OVERRUN <= 1'b1;
            end else if (OVR_CLR) begin
                OVERRUN <= 1'b0;
            end
            if (WR_VALID && err && (ERR_CNT != 8'hFF)) begin
                ERR_CNT <= ERR_CNT + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo; one instance stores errored frames, one drops them.
module tb_uart_rx_fifo;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] WR_DATA = '0;
    logic       WR_PAR_ERR = 1'b0;
    logic       WR_STP_ERR = 1'b0;
    logic       WR_VALID = 1'b0;
    logic       RD_READY = 1'b0;
    logic       OVR_CLR = 1'b0;

    logic [7:0] rd_data0, rd_data1;
    logic       rd_par0, rd_par1, rd_stp0, rd_stp1, rd_valid0, rd_valid1;
    logic [3:0] count0, count1;
    logic       full0, full1, empty0, empty1, ovr0, ovr1;
    logic [7:0] errcnt0, errcnt1;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3), .DROP_ERR_FRAMES(0)) dut0 (
        .CLK(CLK), .RST(RST), .WR_DATA(WR_DATA), .WR_PAR_ERR(WR_PAR_ERR),
        .WR_STP_ERR(WR_STP_ERR), .WR_VALID(WR_VALID), .RD_READY(RD_READY), .OVR_CLR(OVR_CLR),
        .RD_DATA(rd_data0), .RD_PAR_ERR(rd_par0), .RD_STP_ERR(rd_stp0), .RD_VALID(rd_valid0),
        .FIFO_COUNT(count0), .FULL(full0), .EMPTY(empty0), .OVERRUN(ovr0), .ERR_CNT(errcnt0)
    );

    uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3), .DROP_ERR_FRAMES(1)) dut1 (
        .CLK(CLK), .RST(RST), .WR_DATA(WR_DATA), .WR_PAR_ERR(WR_PAR_ERR),
        .WR_STP_ERR(WR_STP_ERR), .WR_VALID(WR_VALID), .RD_READY(RD_READY), .OVR_CLR(OVR_CLR),
        .RD_DATA(rd_data1), .RD_PAR_ERR(rd_par1), .RD_STP_ERR(rd_stp1), .RD_VALID(rd_valid1),
        .FIFO_COUNT(count1), .FULL(full1), .EMPTY(empty1), .OVERRUN(ovr1), .ERR_CNT(errcnt1)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d, input logic pe, input logic se);
        WR_DATA = d; WR_PAR_ERR = pe; WR_STP_ERR = se; WR_VALID = 1'b1;
        tick();
        WR_VALID = 1'b0; WR_PAR_ERR = 1'b0; WR_STP_ERR = 1'b0;
    endtask

    initial begin
        logic [7:0] d;

        // Reset state
        tick(); tick();
        chk("rst_count", count0, 0);
        chk("rst_empty", empty0, 1);
        chk("rst_full", full0, 0);
        chk("rst_valid", rd_valid0, 0);
        chk("rst_data", rd_data0, 0);
        chk("rst_par", rd_par0, 0);
        chk("rst_stp", rd_stp0, 0);
        chk("rst_ovr", ovr0, 0);
        chk("rst_errcnt", errcnt0, 0);
        RST = 1'b1;
        tick();

        // Basic frame
        wr(8'hA5, 1'b0, 1'b0);
        chk("basic_valid", rd_valid0, 1);
        chk("basic_data", rd_data0, 8'hA5);
        chk("basic_count", count0, 1);
        RD_READY = 1'b1;
        tick();
        RD_READY = 1'b0;
        chk("basic_empty", empty0, 1);
        chk("basic_gate", rd_data0, 0);
        chk("basic_novalid", rd_valid0, 0);

        // Fill, overrun, ordered drain
        for (int i = 1; i <= 8; i++) wr(8'(i), 1'b0, 1'b0);
        chk("fill_full", full0, 1);
        chk("fill_count", count0, 8);
        chk("fill_ovr0", ovr0, 0);
        wr(8'h09, 1'b0, 1'b0);
        chk("ovr_set", ovr0, 1);
        chk("ovr_count", count0, 8);
        RD_READY = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_data", rd_data0, i);
            tick();
        end
        RD_READY = 1'b0;
        chk("drain_empty", empty0, 1);
        OVR_CLR = 1'b1;
        tick();
        OVR_CLR = 1'b0;
        chk("ovr_clr", ovr0, 0);

        // Full with simultaneous write and pop
        for (int i = 0; i < 8; i++) wr(8'(8'h11 + i), 1'b0, 1'b0);
        chk("full2_full", full0, 1);
        RD_READY = 1'b1;
        wr(8'h55, 1'b0, 1'b0);
        RD_READY = 1'b0;
        chk("simul_count", count0, 8);
        chk("simul_ovr", ovr0, 0);
        chk("simul_head", rd_data0, 8'h12);
        RD_READY = 1'b1;
        for (int i = 0; i < 7; i++) begin
            chk("simul_drain", rd_data0, 8'h12 + i);
            tick();
        end
        chk("simul_last", rd_data0, 8'h55);
        tick();
        RD_READY = 1'b0;
        chk("simul_empty", empty0, 1);

        // Wrap-around: 20 write/pop pairs
        for (int i = 0; i < 20; i++) begin
            d = 8'(i * 37 + 5);
            wr(d, 1'b0, 1'b0);
            chk("wrap_data", rd_data0, d);
            chk("wrap_count", count0, 1);
            RD_READY = 1'b1;
            tick();
            RD_READY = 1'b0;
        end
        chk("wrap_empty", empty0, 1);
        chk("wrap_empty_drop", empty1, 1);

        // Error handling on both variants
        RST = 1'b0; #1; RST = 1'b1;
        tick();
        wr(8'h3C, 1'b1, 1'b0);
        chk("err_par_flag", rd_par0, 1);
        chk("err_par_data", rd_data0, 8'h3C);
        chk("err_cnt1", errcnt0, 1);
        chk("drop_par_empty", empty1, 1);
        chk("drop_cnt1", errcnt1, 1);
        wr(8'h77, 1'b0, 1'b1);
        chk("err_stp_count", count0, 2);
        chk("drop_stp_count", count1, 0);
        chk("drop_cnt2", errcnt1, 2);
        chk("err_cnt2", errcnt0, 2);
        WR_STP_ERR = 1'b1; WR_VALID = 1'b1;
        for (int i = 0; i < 298; i++) begin
            WR_DATA = 8'(i);
            tick();
        end
        WR_VALID = 1'b0; WR_STP_ERR = 1'b0;
        chk("err_sat", errcnt0, 255);
        chk("drop_sat", errcnt1, 255);
        chk("err_ovr", ovr0, 1);
        chk("drop_no_ovr", ovr1, 0);
        chk("drop_count0", count1, 0);
        chk("err_full", full0, 1);
        chk("err_head_stp", rd_stp0, 0);

        // Overrun clear priority
        OVR_CLR = 1'b1;
        tick();
        chk("clr_only", ovr0, 0);
        wr(8'hEE, 1'b0, 1'b0);
        chk("set_wins", ovr0, 1);
        tick();
        OVR_CLR = 1'b0;
        chk("clr_again", ovr0, 0);

        // Asynchronous reset mid-operation
        RST = 1'b0; #1; RST = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) wr(8'(8'hC0 + i), 1'b0, 1'b0);
        chk("pre_rst_count", count0, 5);
        #2;
        RST = 1'b0;
        #1;
        chk("async_count", count0, 0);
        chk("async_valid", rd_valid0, 0);
        chk("async_data", rd_data0, 0);
        chk("async_empty", empty0, 1);
        tick();
        RST = 1'b1;
        tick();
        chk("post_rst_empty", empty0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
